area_hit_counter: RTL and testbench

- Consumer at the far end of the four-phase dav_/rfd handshake driven by the point-classification unit.
- Receives one 1-bit in-area result per transfer and counts hits over a window of WINDOW samples.
- At window end, publishes hit count and sample count to a downstream consumer over a second dav_/rfd four-phase handshake, then starts a new window.

---
 rtl/area_hit_pkg.sv | 15 +
 rtl/area_hit_counter_if.sv | 23 ++
 rtl/area_hit_counter_window_acc.sv | 31 +++
 rtl/area_hit_counter.sv | 123 ++++++++++++
 tb/tb_area_hit_counter.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/area_hit_pkg.sv
// Shared types and defaults for the area hit counter: FSM state encoding and
// default window/timeout lengths.
package area_hit_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ACK,
      S_PUB,
      S_REL
   } state_t;

   localparam int DEFAULT_WINDOW  = 16;
   localparam int DEFAULT_TIMEOUT = 64;

endpackage

// File: rtl/area_hit_counter_if.sv
// Handshake bundle for the area hit counter: upstream sample transfer
// (dav_/z/rfd) and downstream window publish (out_dav_/out_rfd/hits/samples).
interface area_hit_counter_if #(
   parameter int CW = 5
);
   logic          dav_;
   logic          z;
   logic          rfd;
   logic          out_dav_;
   logic          out_rfd;
   logic [CW-1:0] hits;
   logic [CW-1:0] samples;

   modport master (
      output dav_, z, out_rfd,
      input  rfd, out_dav_, hits, samples
   );

   modport slave (
      input  dav_, z, out_rfd,
      output rfd, out_dav_, hits, samples
   );
endinterface

// File: rtl/area_hit_counter_window_acc.sv
// Window accumulator: counts samples and hits for the current window; full
// flags that WINDOW samples have been taken.
module window_acc #(
   parameter int WINDOW = 16,
   parameter int CW     = $clog2(WINDOW + 1)
) (
   input  logic          clock,
   input  logic          reset_,
   input  logic          clr,
   input  logic          inc,
   input  logic          sample_bit,
   output logic [CW-1:0] hit_cnt,
   output logic [CW-1:0] smp_cnt,
   output logic          full
);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of block ordering.
   always_ff @(posedge clock) begin
      if (reset_ || clr) begin
         hit_cnt <= '0;
         smp_cnt <= '0;
      end else if (inc) begin
         hit_cnt <= hit_cnt + CW'(sample_bit);
         smp_cnt <= smp_cnt + CW'(1);
      end
   end

   assign full = (smp_cnt == CW'(WINDOW));

endmodule

// File: rtl/area_hit_counter.sv
// Area hit counter: four-phase consumer of in-area bits, publishes hit/sample
// counts per window downstream. Optional partial-window timeout: AREA_HIT_TIMEOUT_EN.
module area_hit_counter
   import area_hit_pkg::*;
#(
   parameter int WINDOW = DEFAULT_WINDOW
`ifdef AREA_HIT_TIMEOUT_EN
   , parameter int TIMEOUT = DEFAULT_TIMEOUT
`endif
) (
   input  logic              clock,
   input  logic              reset_,
   area_hit_counter_if.slave bus
);

   localparam int CW = $clog2(WINDOW + 1);

   state_t        state;
   logic          rfd_q;
   logic          out_dav_q;
   logic [CW-1:0] hits_q;
   logic [CW-1:0] samples_q;
   logic [CW-1:0] hit_cnt;
   logic [CW-1:0] smp_cnt;
   logic          full;
   logic          inc;
   logic          clr;
   logic          timeout_hit;

   assign inc = (state == S_IDLE) && !bus.dav_;
   assign clr = (state == S_PUB) && !bus.out_rfd;

   window_acc #(
      .WINDOW (WINDOW),
      .CW     (CW)
   ) u_acc (
      .clock      (clock),
      .reset_     (reset_),
      .clr        (clr),
      .inc        (inc),
      .sample_bit (bus.z),
      .hit_cnt    (hit_cnt),
      .smp_cnt    (smp_cnt),
      .full       (full)
   );

`ifdef AREA_HIT_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);
   logic [TW-1:0] idle_cnt;

   // Fires on the TIMEOUT-th consecutive idle clock holding a partial window.
   assign timeout_hit = (state == S_IDLE) && bus.dav_ && (smp_cnt != '0) &&
                        (idle_cnt == TW'(TIMEOUT - 1));

   always_ff @(posedge clock) begin
      if (reset_) begin
         idle_cnt <= '0;
      end else if (state != S_IDLE || !bus.dav_ || smp_cnt == '0 || timeout_hit) begin
         idle_cnt <= '0;
      end else begin
         idle_cnt <= idle_cnt + TW'(1);
      end
   end
`else
   assign timeout_hit = 1'b0;
`endif

   always_ff @(posedge clock) begin
      if (reset_) begin
         state     <= S_IDLE;
         rfd_q     <= 1'b1;
         out_dav_q <= 1'b1;
         hits_q    <= '0;
         samples_q <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               rfd_q     <= 1'b1;
               out_dav_q <= 1'b1;
               if (!bus.dav_) begin
                  rfd_q <= 1'b0;
                  state <= S_ACK;
               end else if (timeout_hit) begin
                  hits_q    <= hit_cnt;
                  samples_q <= smp_cnt;
                  out_dav_q <= 1'b0;
                  state     <= S_PUB;
               end
            end
            S_ACK: begin
               if (bus.dav_) begin
                  rfd_q <= 1'b1;
                  if (full) begin
                     hits_q    <= hit_cnt;
                     samples_q <= smp_cnt;
                     out_dav_q <= 1'b0;
                     state     <= S_PUB;
                  end else begin
                     state <= S_IDLE;
                  end
               end
            end
            // Upstream dav_ is ignored here; the producer stalls until rfd falls.
            S_PUB: begin
               if (!bus.out_rfd) begin
                  out_dav_q <= 1'b1;
                  state     <= S_REL;
               end
            end
            S_REL: begin
               if (bus.out_rfd) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.rfd      = rfd_q;
   assign bus.out_dav_ = out_dav_q;
   assign bus.hits     = hits_q;
   assign bus.samples  = samples_q;

endmodule

// File: tb/tb_area_hit_counter.sv
// Self-checking bench for area_hit_counter: three window sizes, directed and
// random four-phase traffic against a window-sum reference model.
module tb_area_hit_counter;

   logic clock;
   logic reset_;
   logic dav_;
   logic z;
   logic out_rfd;
   int   sel;
   int   errors;
   int   checks;
   bit   model_q[$];

   logic       obs_rfd;
   logic       obs_out_dav_;
   logic [4:0] obs_hits;
   logic [4:0] obs_samples;

   area_hit_counter_if #(.CW(3)) if4 ();
   area_hit_counter_if #(.CW(1)) if1 ();
   area_hit_counter_if #(.CW(5)) if16 ();

   assign if4.dav_     = dav_;
   assign if4.z        = z;
   assign if4.out_rfd  = out_rfd;
   assign if1.dav_     = dav_;
   assign if1.z        = z;
   assign if1.out_rfd  = out_rfd;
   assign if16.dav_    = dav_;
   assign if16.z       = z;
   assign if16.out_rfd = out_rfd;

   area_hit_counter #(
      .WINDOW (4)
`ifdef AREA_HIT_TIMEOUT_EN
      , .TIMEOUT (8)
`endif
   ) dut4 (
      .clock  (clock),
      .reset_ (reset_),
      .bus    (if4.slave)
   );

   area_hit_counter #(.WINDOW(1)) dut1 (
      .clock  (clock),
      .reset_ (reset_),
      .bus    (if1.slave)
   );

   area_hit_counter #(.WINDOW(16)) dut16 (
      .clock  (clock),
      .reset_ (reset_),
      .bus    (if16.slave)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   always_comb begin
      obs_rfd      = if4.rfd;
      obs_out_dav_ = if4.out_dav_;
      obs_hits     = 5'(if4.hits);
      obs_samples  = 5'(if4.samples);
      case (sel)
         1: begin
            obs_rfd      = if1.rfd;
            obs_out_dav_ = if1.out_dav_;
            obs_hits     = 5'(if1.hits);
            obs_samples  = 5'(if1.samples);
         end
         16: begin
            obs_rfd      = if16.rfd;
            obs_out_dav_ = if16.out_dav_;
            obs_hits     = if16.hits;
            obs_samples  = if16.samples;
         end
         default: ;
      endcase
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic do_reset();
      reset_  = 1'b1;
      dav_    = 1'b1;
      z       = 1'b0;
      out_rfd = 1'b1;
      @(negedge clock);
      reset_  = 1'b0;
      model_q.delete();
   endtask

   // Full four-phase producer transfer with exact one-clock rfd latencies.
   task automatic send(input logic zv);
      dav_ = 1'b0;
      z    = zv;
      @(negedge clock);
      check("rfd_fall", obs_rfd, 1'b0);
      dav_ = 1'b1;
      @(negedge clock);
      check("rfd_rise", obs_rfd, 1'b1);
   endtask

   task automatic consume(input int exp_hits, input int exp_samples);
      int n = 0;
      while (obs_out_dav_ !== 1'b0 && n < 100) begin
         @(negedge clock);
         n++;
      end
      check("pub_wait", obs_out_dav_, 1'b0);
      check("pub_hits", obs_hits, exp_hits);
      check("pub_samples", obs_samples, exp_samples);
      out_rfd = 1'b0;
      @(negedge clock);
      check("pub_release", obs_out_dav_, 1'b1);
      out_rfd = 1'b1;
      @(negedge clock);
   endtask

   function automatic int model_hits();
      int s = 0;
      foreach (model_q[i]) s += int'(model_q[i]);
      return s;
   endfunction

   // Sends one sample to the WINDOW=4 unit and checks the window boundary.
   task automatic model_send(input logic zv, input bit do_consume);
      model_q.push_back(zv);
      send(zv);
      if (model_q.size() == 4) begin
         check("win_end_out_dav", obs_out_dav_, 1'b0);
         if (do_consume) begin
            consume(model_hits(), 4);
            model_q.delete();
         end
      end else begin
         check("mid_win_out_dav", obs_out_dav_, 1'b1);
      end
   endtask

   initial begin
      int n;
      logic zr;
      errors = 0;
      checks = 0;
      sel    = 4;

      do_reset();
      check("rst_rfd", obs_rfd, 1'b1);
      check("rst_out_dav", obs_out_dav_, 1'b1);
      check("rst_hits", obs_hits, 0);
      check("rst_samples", obs_samples, 0);

      // Reset while acknowledging the third hit discards the partial window.
      send(1'b1);
      send(1'b1);
      dav_ = 1'b0;
      z    = 1'b1;
      @(negedge clock);
      check("ack_rfd", obs_rfd, 1'b0);
      reset_ = 1'b1;
      dav_   = 1'b1;
      @(negedge clock);
      reset_ = 1'b0;
      model_q.delete();
      check("midrst_rfd", obs_rfd, 1'b1);
      check("midrst_out_dav", obs_out_dav_, 1'b1);
      check("midrst_hits", obs_hits, 0);
      check("midrst_samples", obs_samples, 0);

      model_send(1'b1, 1'b1);
      model_send(1'b0, 1'b1);
      model_send(1'b1, 1'b1);
      model_send(1'b1, 1'b1);

      // Downstream stalls while upstream already presents the next sample.
      model_send(1'b0, 1'b0);
      model_send(1'b1, 1'b0);
      model_send(1'b1, 1'b0);
      model_send(1'b0, 1'b0);
      dav_ = 1'b0;
      z    = 1'b1;
      repeat (20) @(negedge clock);
      check("stall_rfd", obs_rfd, 1'b1);
      check("stall_out_dav", obs_out_dav_, 1'b0);
      check("stall_hits", obs_hits, model_hits());
      check("stall_samples", obs_samples, 4);
      model_q.delete();
      out_rfd = 1'b0;
      @(negedge clock);
      check("stall_release", obs_out_dav_, 1'b1);
      check("stall_rel_rfd", obs_rfd, 1'b1);
      out_rfd = 1'b1;
      n = 0;
      while (obs_rfd !== 1'b0 && n < 10) begin
         @(negedge clock);
         n++;
      end
      check("pending_taken", obs_rfd, 1'b0);
      model_q.push_back(1'b1);
      dav_ = 1'b1;
      @(negedge clock);
      check("pending_rfd_rise", obs_rfd, 1'b1);
      model_send(1'b0, 1'b1);
      model_send(1'b0, 1'b1);
      model_send(1'b0, 1'b1);

      for (int w = 0; w < 6; w++) begin
         for (int s = 0; s < 4; s++) begin
            zr = 1'($urandom_range(0, 1));
            model_send(zr, 1'b1);
         end
      end

`ifdef AREA_HIT_TIMEOUT_EN
      do_reset();
      send(1'b1);
      send(1'b0);
      n = 0;
      while (obs_out_dav_ !== 1'b0 && n < 50) begin
         @(negedge clock);
         n++;
      end
      check("timeout_clocks", n, 8);
      consume(1, 2);
`else
      do_reset();
      send(1'b1);
      send(1'b0);
      repeat (30) @(negedge clock);
      check("partial_waits", obs_out_dav_, 1'b1);
`endif

      sel = 1;
      do_reset();
      send(1'b1);
      check("w1_pub1", obs_out_dav_, 1'b0);
      consume(1, 1);
      send(1'b0);
      check("w1_pub2", obs_out_dav_, 1'b0);
      consume(0, 1);

      sel = 16;
      do_reset();
      for (int s = 0; s < 16; s++) begin
         send(1'b1);
         if (s == 14) check("w16_not_yet", obs_out_dav_, 1'b1);
      end
      check("w16_pub", obs_out_dav_, 1'b0);
      consume(16, 16);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
